// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_pkg
// Brief    : Shared AXI response/burst codes and responder FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic c_GRANT_RD = 1'b0;
    localparam logic c_GRANT_WR = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        WR_RESP = 3'd4
    } axi_slv_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_slv_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : axi_slv_lfsr
// Brief    : 8-bit Fibonacci LFSR (taps 8,6,5,4) driving a 0-3 cycle wait counter.
// Revision : 1.0 - initial release
// ============================================================================
module axi_slv_lfsr (
    input  logic aclk,
    input  logic aresetn,
    input  logic load,
    output logic wait_done
);

    logic [7:0] r_lfsr;
    logic [1:0] r_wait;
    logic       w_fb;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_lfsr <= 8'hA5;
            r_wait <= 2'd0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
            if (load) begin
                r_wait <= r_lfsr[1:0];
            end else if (r_wait != 2'd0) begin
                r_wait <= r_wait - 2'd1;
            end
        end
    end

    assign wait_done = (r_wait == 2'd0);

endmodule
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_sram_slave
// Brief    : Single-outstanding AXI responder backed by a word-wide sync SRAM.
//            Optional random wait states under AXI_SLV_RAND_DELAY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int ID_W   = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [3:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    axi_slv_state_t    r_state, w_next;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic              r_err;
    logic              r_last_grant;

    logic w_wait_done;
    logic w_grant_rd;
    logic w_last_beat;
    logic w_ar_hs, w_aw_hs, w_r_hs, w_w_hs;

    // Size and burst type are irrelevant: every burst advances one word per beat.
    logic w_unused;
    assign w_unused = &{1'b0, arsize, arburst, awsize, awburst,
                        araddr[31:ADDR_W+2], araddr[1:0],
                        awaddr[31:ADDR_W+2], awaddr[1:0]};

`ifdef AXI_SLV_RAND_DELAY_EN
    logic w_wait_load;
    // Re-arm the wait counter on entry to any waiting state and between write beats.
    assign w_wait_load = ((w_next != r_state) &&
                          (w_next == IDLE || w_next == RD_DATA || w_next == WR_DATA)) ||
                         (w_w_hs && (w_next == WR_DATA));

    axi_slv_lfsr u_lfsr (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .load      (w_wait_load),
        .wait_done (w_wait_done)
    );
`else
    assign w_wait_done = 1'b1;
`endif

    assign w_last_beat = (r_cnt == r_len);
    assign w_grant_rd  = arvalid && (!awvalid || (r_last_grant == c_GRANT_WR));
    assign w_ar_hs     = arvalid && arready;
    assign w_aw_hs     = awvalid && awready;
    assign w_r_hs      = rvalid && rready;
    assign w_w_hs      = wvalid && wready;
    assign ram_addr    = r_addr;

    always_comb begin
        w_next    = r_state;
        arready   = 1'b0;
        awready   = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        rdata     = '0;
        rresp     = RESP_OKAY;
        rid       = '0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bresp     = RESP_OKAY;
        bid       = '0;
        ram_en    = 1'b0;
        ram_wen   = 4'd0;
        ram_wdata = '0;
        case (r_state)
            IDLE: begin
                // Ready lines are combinational, so gate them while reset is held.
                if (aresetn && w_wait_done) begin
                    if (w_grant_rd) begin
                        arready = 1'b1;
                        w_next  = RD_REQ;
                    end else if (awvalid) begin
                        awready = 1'b1;
                        w_next  = WR_DATA;
                    end
                end
            end
            RD_REQ: begin
                ram_en = 1'b1;
                w_next = RD_DATA;
            end
            RD_DATA: begin
                if (w_wait_done) begin
                    rvalid = 1'b1;
                    rdata  = ram_rdata;
                    rid    = r_id;
                    rlast  = w_last_beat;
                    if (rready) begin
                        w_next = w_last_beat ? IDLE : RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                if (w_wait_done) begin
                    wready = 1'b1;
                    if (wvalid) begin
                        ram_en    = 1'b1;
                        ram_wen   = wstrb;
                        ram_wdata = wdata;
                        if (w_last_beat) begin
                            w_next = WR_RESP;
                        end
                    end
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                bid    = r_id;
                bresp  = r_err ? RESP_SLVERR : RESP_OKAY;
                if (bready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= IDLE;
            r_id         <= '0;
            r_addr       <= '0;
            r_len        <= 8'd0;
            r_cnt        <= 8'd0;
            r_err        <= 1'b0;
            r_last_grant <= c_GRANT_WR;
        end else begin
            r_state <= w_next;
            if (w_ar_hs) begin
                r_id         <= arid;
                r_addr       <= araddr[ADDR_W+1:2];
                r_len        <= arlen;
                r_cnt        <= 8'd0;
                r_last_grant <= c_GRANT_RD;
            end else if (w_aw_hs) begin
                r_id         <= awid;
                r_addr       <= awaddr[ADDR_W+1:2];
                r_len        <= {4'd0, awlen};
                r_cnt        <= 8'd0;
                r_err        <= 1'b0;
                r_last_grant <= c_GRANT_WR;
            end else if ((w_r_hs && !w_last_beat) || w_w_hs) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_cnt  <= r_cnt + 8'd1;
            end
            // The beat count ends the burst; a wlast that disagrees only poisons the response.
            if (w_w_hs && (wlast != w_last_beat)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_sram_slave
// Brief    : Scoreboard bench for axi_sram_slave with a behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;

    localparam int ADDR_W = 16;
    localparam int ID_W   = 4;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [ID_W-1:0]   arid = '0, awid = '0;
    logic [31:0]       araddr = '0, awaddr = '0;
    logic [7:0]        arlen = '0;
    logic [3:0]        awlen = '0;
    logic [2:0]        arsize = 3'd2, awsize = 3'd2;
    logic [1:0]        arburst = 2'b01, awburst = 2'b01;
    logic              arvalid = 1'b0, awvalid = 1'b0;
    logic              arready, awready;
    logic [ID_W-1:0]   rid, bid;
    logic [31:0]       rdata;
    logic [1:0]        rresp, bresp;
    logic              rlast, rvalid, bvalid, wready;
    logic              rready = 1'b1, bready = 1'b1;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wlast = 1'b0, wvalid = 1'b0;
    logic              ram_en;
    logic [3:0]        ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = '0;

    axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc++;

    // Behavioural SRAM: one-cycle read latency, output held while idle.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge aclk) begin
        if (ram_en) begin
            if (ram_wen == 4'd0) begin
                ram_rdata <= mem[ram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wen[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
                end
            end
        end
    end

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        logic            last;
        int              lat;
    } r_exp_t;
    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_exp_t;

    r_exp_t rq[$];
    b_exp_t bq[$];
    bit     rr_q[$];
    bit     bb_q[$];

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_r(input logic [ID_W-1:0] id, input logic [31:0] data, input logic last);
        r_exp_t e;
        e.id = id; e.data = data; e.last = last; e.lat = 2;
        rq.push_back(e);
    endtask

    task automatic push_b(input logic [ID_W-1:0] id, input logic [1:0] resp);
        b_exp_t e;
        e.id = id; e.resp = resp;
        bq.push_back(e);
    endtask

    // Ready drivers: consume one pattern bit per cycle the DUT holds valid.
    always @(posedge aclk) begin
        #1;
        if (rvalid && rr_q.size() > 0) rready = rr_q.pop_front();
        else rready = 1'b1;
        if (bvalid && bb_q.size() > 0) bready = bb_q.pop_front();
        else bready = 1'b1;
    end

    // Monitor / scoreboard
    int          last_evt = 0;
    int          r_beats = 0;
    bit          r_seen = 0;
    logic [31:0] r_hold = '0;
    r_exp_t      m_re;
    b_exp_t      m_be;

    always @(negedge aclk) begin
        if (!aresetn) begin
            r_seen = 0;
        end else begin
            if (arvalid && arready) last_evt = cyc;
            if (rvalid) begin
                if (rq.size() == 0) begin
                    check("r_unexpected", 32'(rq.size()), 32'd1);
                end else begin
                    if (!r_seen) begin
                        r_seen = 1;
                        r_hold = rdata;
                        check("r_latency", 32'(cyc - last_evt), 32'(rq[0].lat));
                    end else begin
                        check("r_hold", rdata, r_hold);
                    end
                    if (rready) begin
                        m_re = rq.pop_front();
                        check("r_data", rdata, m_re.data);
                        check("r_last", 32'(rlast), 32'(m_re.last));
                        check("r_id", 32'(rid), 32'(m_re.id));
                        check("r_resp", 32'(rresp), 32'd0);
                        r_seen = 0;
                        last_evt = cyc;
                        r_beats++;
                    end
                end
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    check("b_unexpected", 32'(bq.size()), 32'd1);
                end else begin
                    m_be = bq.pop_front();
                    check("b_id", 32'(bid), 32'(m_be.id));
                    check("b_resp", 32'(bresp), 32'(m_be.resp));
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic ar_send(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len);
        bit ok = 0;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk);
            ok = arready;
        end
        if (!ok) check("ar_timeout", 32'(ok), 32'd1);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic aw_send(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len);
        bit ok = 0;
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk);
            ok = awready;
        end
        if (!ok) check("aw_timeout", 32'(ok), 32'd1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        bit ok = 0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk);
            ok = wready;
        end
        if (!ok) check("w_timeout", 32'(ok), 32'd1);
        tick();
        wvalid = 1'b0;
    endtask

    task automatic wait_grant();
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk);
            ok = arready || awready;
        end
        if (!ok) check("grant_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && (rq.size() > 0 || bq.size() > 0); i++) tick();
        check("drain", 32'(rq.size() + bq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        // Requests held high during reset must not leak through the ready lines.
        arvalid = 1'b1;
        awvalid = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_ready", 32'({arready, awready}), 32'd0);
        check("rst_ctrl", 32'({rvalid, rlast, wready, bvalid, ram_en, ram_wen}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ids", 32'({rid, bid, bresp, rresp}), 32'd0);
        arvalid = 1'b0;
        awvalid = 1'b0;
        aresetn = 1'b1;
        tick();
        tick();

        // Arbitration: read first, then write, then read again.
        mem[16'h0040] = 32'hDEADBEEF;
        push_r(4'd1, 32'hDEADBEEF, 1'b1);
        push_r(4'd1, 32'hDEADBEEF, 1'b1);
        push_b(4'd7, 2'b00);
        arid = 4'd1; araddr = 32'h100; arlen = 8'd0; arvalid = 1'b1;
        awid = 4'd7; awaddr = 32'h10;  awlen = 4'd0; awvalid = 1'b1;
        @(negedge aclk);
        check("grant1_rd", 32'({arready, awready}), 32'd2);
        tick();
        wait_grant();
        check("grant2_wr", 32'({arready, awready}), 32'd1);
        tick();
        awvalid = 1'b0;
        w_send(32'hCAFEF00D, 4'hF, 1'b1);
        wait_grant();
        check("grant3_rd", 32'({arready, awready}), 32'd2);
        tick();
        arvalid = 1'b0;
        drain();

        // Upper address bits alias: 0x40010 selects word 4.
        push_r(4'd2, 32'hCAFEF00D, 1'b1);
        ar_send(4'd2, 32'h0004_0010, 8'd0);
        drain();

        // Single read
        push_r(4'd3, 32'hDEADBEEF, 1'b1);
        ar_send(4'd3, 32'h100, 8'd0);
        drain();

        // Strobed write with a stalled response, then read back
        mem[2] = 32'hFFFFFFFF;
        bb_q = '{1'b0, 1'b0};
        push_b(4'd5, 2'b00);
        aw_send(4'd5, 32'h8, 4'd0);
        w_send(32'h11223344, 4'b0011, 1'b1);
        drain();
        push_r(4'd2, 32'hFFFF3344, 1'b1);
        ar_send(4'd2, 32'h8, 8'd0);
        drain();

        // 4-beat burst with rready 1,0,0,1
        mem[0] = 32'h1000_0000; mem[1] = 32'h1000_0001;
        mem[2] = 32'h1000_0002; mem[3] = 32'h1000_0003;
        rr_q = '{1'b1, 1'b0, 1'b0, 1'b1};
        push_r(4'd4, 32'h1000_0000, 1'b0);
        push_r(4'd4, 32'h1000_0001, 1'b0);
        push_r(4'd4, 32'h1000_0002, 1'b0);
        push_r(4'd4, 32'h1000_0003, 1'b1);
        ar_send(4'd4, 32'h0, 8'd3);
        drain();

        // awlen=3 with early wlast: all beats written, SLVERR
        push_b(4'd6, 2'b10);
        aw_send(4'd6, 32'h20, 4'd3);
        w_send(32'hA000_0000, 4'hF, 1'b0);
        w_send(32'hA000_0001, 4'hF, 1'b1);
        w_send(32'hA000_0002, 4'hF, 1'b0);
        w_send(32'hA000_0003, 4'hF, 1'b0);
        drain();
        push_r(4'd6, 32'hA000_0000, 1'b0);
        push_r(4'd6, 32'hA000_0001, 1'b0);
        push_r(4'd6, 32'hA000_0002, 1'b0);
        push_r(4'd6, 32'hA000_0003, 1'b1);
        ar_send(4'd6, 32'h20, 8'd3);
        drain();

        // Address wrap from the last word back to word 0
        mem[16'hFFFF] = 32'h5A5A_0001;
        push_r(4'd8, 32'h5A5A_0001, 1'b0);
        push_r(4'd8, 32'h1000_0000, 1'b1);
        ar_send(4'd8, 32'h0003_FFFC, 8'd1);
        drain();

        // Reset during beat 2 of an 8-beat read
        for (int i = 0; i < 8; i++) begin
            mem[16 + i] = 32'hB000_0000 + 32'(i);
            push_r(4'd9, 32'hB000_0000 + 32'(i), (i == 7) ? 1'b1 : 1'b0);
        end
        rr_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        base = r_beats;
        ar_send(4'd9, 32'h40, 8'd7);
        begin
            bit hit = 0;
            for (int i = 0; i < 100 && !hit; i++) begin
                @(negedge aclk);
                hit = rvalid && (r_beats - base == 2);
            end
            check("midrst_reach_beat2", 32'(hit), 32'd1);
        end
        #2;
        aresetn = 1'b0;
        #1;
        check("midrst_ctrl", 32'({arready, awready, rvalid, rlast, wready, bvalid, ram_en}), 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_ids", 32'({rid, bid, bresp, ram_wen}), 32'd0);
        rq.delete();
        rr_q.delete();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        tick();
        push_r(4'd3, 32'hDEADBEEF, 1'b1);
        ar_send(4'd3, 32'h100, 8'd0);
        drain();

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI responder that terminates the CPU's AXI master port (ar/r/aw/w/b channels) and serves the transfers from a word-wide synchronous SRAM. It is the memory-side counterpart of the core's `axi_interface`. It is used as the SoC-less memory model in simulation and as the on-chip RAM bridge in FPGA builds. One transaction is outstanding at a time, with INCR bursts supported on both directions.

## Interface
Parameters:
- ADDR_W, 16, SRAM word-address width; SRAM holds 2^ADDR_W 32-bit words.
- ID_W, 4, width of arid/rid/awid/bid.

Ports, one channel per line (direction, widths in field order):
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- arid, araddr, arlen, arsize, arburst, arvalid  in  ID_W/32/8/3/2/1  read address channel.
- arready  out  1  read address accept.
- rid, rdata, rresp, rlast, rvalid  out  ID_W/32/2/1/1  read data channel.
- rready  in  1  master accepts read beat.
- awid, awaddr, awlen, awsize, awburst, awvalid  in  ID_W/32/4/3/2/1  write address channel.
- awready  out  1  write address accept.
- wdata, wstrb, wlast, wvalid  in  32/4/1/1  write data channel; wid is not a port and is ignored.
- wready  out  1  write beat accept.
- bid, bresp, bvalid  out  ID_W/2/1  write response channel.
- bready  in  1  master accepts response.
- ram_en, ram_wen, ram_addr, ram_wdata  out  1/4/ADDR_W/32  SRAM request; `ram_wen==0` means read.
- ram_rdata  in  32  SRAM read data.
  - Valid the cycle after `ram_en`.
  - Held while `ram_en` is low.

## Operation
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP. Reset state is IDLE.
- IDLE arbitration (read vs write):
  - arready / awready are combinational and asserted only in IDLE, to the granted requester.
  - If only one of arvalid / awvalid is high, that one is granted.
  - If both are high, grant round-robin: the opposite of `last_grant`.
  - `last_grant` resets to write, so the first conflict grants read.
- On any handshake, latch id, the word address (addr[ADDR_W+1:2]) and len.
  - Address bits above ADDR_W+1 are ignored (aliasing).
  - Address increments by one word per beat regardless of size/burst; every burst type is treated as INCR.
- Read path:
  - RD_REQ: drive ram_en=1, ram_wen=0, ram_addr=beat address; go to RD_DATA.
  - RD_DATA: rvalid=1, rdata=ram_rdata, rresp=2'b00, rid=latched id, rlast=(beat_cnt==len).
  - On rvalid&rready: if last beat, go to IDLE; else increment address and beat_cnt and go to RD_REQ.
- Write path:
  - WR_DATA: wready=1.
  - On wvalid&wready: ram_en=1, ram_wen=wstrb, ram_wdata=wdata, same cycle; then increment address and beat_cnt.
  - The beat count decides the final beat (beat_cnt==awlen), not wlast.
  - On the final beat go to WR_RESP.
  - If wlast was ever seen mismatched (early or missing), the response is SLVERR.
  - WR_RESP: bvalid=1, bid=latched id, bresp=2'b00 (OKAY) or 2'b10 (SLVERR). On bready, go to IDLE.
- Other ram_en: low in every state and case not listed above.

## Timing
- While aresetn=0, all outputs are 0: arready, awready, rvalid, rlast, wready, bvalid, ram_en, ram_wen, rdata, bresp, rid, bid.
- Reset asserted mid-burst: FSM returns to IDLE immediately; beats in flight are discarded and no response is issued.
- Read latency: ar handshake at cycle T, first rvalid at T+2; each later beat's rvalid comes 2 cycles after the previous r handshake.
- Write: awready at T, wready from T+1; each w handshake is one cycle; bvalid follows the cycle after the final beat.
- Backpressure:
  - rvalid and rdata stay stable while rready=0, because ram_en is low and the SRAM holds its output.
  - bvalid stays stable while bready=0.
- arlen=255 (256 beats) and awlen=15 (16 beats) are legal maxima.
- Address wraps modulo 2^ADDR_W words.

## Configuration
- `AXI_SLV_RAND_DELAY_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset, advances every cycle) inserts wait states.
  - The wait count is lfsr[1:0] cycles (0–3): before arready/awready in IDLE, before each rvalid, and before each wready beat.
  - The wait is sampled on entry to the waiting state.
- Undefined: zero wait states; timing is exactly as above.

## Structure
- Shared package `axi_pkg`:
  - Response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Burst codes.
  - FSM state enum.
- Sub-module `axi_slv_lfsr`: LFSR plus wait counter, exposing `wait_done`. Instantiated only under the macro.

## Test plan
- Single read: araddr=0x100, arlen=0, RAM word 0x40=0xDEADBEEF -> rvalid at T+2, rdata=0xDEADBEEF, rlast=1, rresp=0.
- Strobed write: awaddr=0x8, wdata=0x11223344, wstrb=4'b0011, old word 0xFFFFFFFF -> word 2 reads back 0xFFFF3344, bresp=0.
- 4-beat read burst at 0x0 with rready toggled 1,0,0,1 -> beats 0..3 delivered in order, data held during stalls, rlast only on beat 3.
- arvalid and awvalid both raised after reset -> read granted first; the next conflict grants write.
- awlen=3 with wlast on beat 1 -> all 4 beats still written, bresp=2'b10.
- aresetn dropped during beat 2 of an 8-beat read -> all outputs 0 immediately; next read after release is served normally.
